// File: rtl/instr_decode_pkg.sv
// rtl/instr_decode_pkg.sv - decoded uop types and the micro-code expansion table
package instr_decode;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_nxt;
        logic [15:0] simid;
        logic [7:0]  opcode;
        logic [15:0] imm;
    } t_uinstr;

    typedef struct packed {
        logic valid;
    } t_nuke_pkt;

    typedef struct packed {
        t_uinstr step;
        logic    last;
    } t_uexp;

    // opcode[7] marks a multi-step uop whose length minus one is opcode[1:0];
    // each step keeps the parent's pc/pc_nxt/simid and offsets imm by its index.
    function automatic t_uexp f_ucode_expand(input t_uinstr uop, input logic [1:0] idx);
        t_uexp r;
        r.step = uop;
        r.last = 1'b1;
        if (uop.opcode[7]) begin
            r.step.imm = uop.imm + 16'(idx);
            r.last     = (idx == uop.opcode[1:0]);
        end
        return r;
    endfunction

endpackage

// File: rtl/ucode_seq_if.sv
// rtl/ucode_seq_if.sv - DE1 pop and UC1 output handshakes of the micro-code sequencer
interface ucode_seq_if #(parameter int SEQ_IDX_W = 2);
    import instr_decode::*;

    logic                 valid_de1;
    t_uinstr              uinstr_de1;
    logic                 ucode_ready_uc0;
    logic                 rename_ready_rn0;
    logic                 valid_uc1;
    t_uinstr              uinstr_uc1;
    logic [SEQ_IDX_W-1:0] useq_idx_uc1;
    logic                 useq_last_uc1;

    modport master (
        output valid_de1, uinstr_de1, rename_ready_rn0,
        input  ucode_ready_uc0, valid_uc1, uinstr_uc1, useq_idx_uc1, useq_last_uc1
    );

    modport slave (
        input  valid_de1, uinstr_de1, rename_ready_rn0,
        output ucode_ready_uc0, valid_uc1, uinstr_uc1, useq_idx_uc1, useq_last_uc1
    );

endinterface

// File: rtl/ucode_seq.sv
// rtl/ucode_seq.sv - UC0/UC1 micro-code sequencer: passes single-step uops, expands multi-step ones
module ucode_seq
    import instr_decode::*;
#(
    parameter int MAX_SEQ   = 4,
    parameter int SEQ_IDX_W = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  t_nuke_pkt      nuke_rb1,
    ucode_seq_if.slave     bus
);

    typedef enum logic {IDLE, SEQ} t_state;

    t_state               state, state_nxt;
    logic [SEQ_IDX_W-1:0] cnt, cnt_nxt;
    t_uinstr              parent, parent_nxt;

    logic                 adv, nuke, step_last;
    logic [SEQ_IDX_W-1:0] exp_idx;
    t_uinstr              exp_src;
    t_uexp                exp_step;

    logic                 valid_nxt, last_nxt;
    t_uinstr              uinstr_nxt;
    logic [SEQ_IDX_W-1:0] idx_nxt;

    assign nuke = nuke_rb1.valid;
    assign adv  = ~bus.valid_uc1 | bus.rename_ready_rn0;
    assign bus.ucode_ready_uc0 = (state == IDLE) & adv & ~nuke & ~reset;

    // The step to emit comes from the incoming uop in IDLE, from the latched parent in SEQ.
    always_comb begin
        exp_idx   = (state == SEQ) ? cnt : '0;
        exp_src   = (state == SEQ) ? parent : bus.uinstr_de1;
        exp_step  = f_ucode_expand(exp_src, exp_idx);
        step_last = exp_step.last | (exp_idx == SEQ_IDX_W'(MAX_SEQ - 1));
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        parent_nxt = parent;
        valid_nxt  = bus.valid_uc1;
        uinstr_nxt = bus.uinstr_uc1;
        idx_nxt    = bus.useq_idx_uc1;
        last_nxt   = bus.useq_last_uc1;
        if (nuke) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            valid_nxt = 1'b0;
        end else if (adv) begin
            valid_nxt = 1'b0;
            if (state == SEQ || bus.valid_de1) begin
                valid_nxt  = 1'b1;
                uinstr_nxt = exp_step.step;
                idx_nxt    = exp_idx;
                last_nxt   = step_last;
                if (step_last) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = SEQ;
                    cnt_nxt   = exp_idx + 1'b1;
                    if (state == IDLE) parent_nxt = bus.uinstr_de1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            parent <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            parent <= parent_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.valid_uc1     <= 1'b0;
            bus.uinstr_uc1    <= '0;
            bus.useq_idx_uc1  <= '0;
            bus.useq_last_uc1 <= 1'b0;
        end else begin
            bus.valid_uc1     <= valid_nxt;
            bus.uinstr_uc1    <= uinstr_nxt;
            bus.useq_idx_uc1  <= idx_nxt;
            bus.useq_last_uc1 <= last_nxt;
        end
    end

`ifndef SYNTHESIS
    int unsigned parent_cnt, uop_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parent_cnt <= 0;
            uop_cnt    <= 0;
        end else begin
            if (bus.valid_de1 & ~nuke) parent_cnt <= parent_cnt + 32'd1;
            if (bus.valid_uc1 & bus.rename_ready_rn0) uop_cnt <= uop_cnt + 32'd1;
        end
    end

    // Decode flushes in a nuke cycle, so a pop against a nuke is not a protocol error.
    a_pop_when_ready: assert property (@(posedge clk) disable iff (reset)
        (bus.valid_de1 & ~nuke) |-> bus.ucode_ready_uc0);

    a_stall_stable: assert property (@(posedge clk) disable iff (reset)
        (bus.valid_uc1 & ~bus.rename_ready_rn0 & ~nuke) |=>
        (bus.valid_uc1 & $stable(bus.uinstr_uc1) & $stable(bus.useq_idx_uc1) & $stable(bus.useq_last_uc1)));

    a_idx_step: assert property (@(posedge clk) disable iff (reset)
        (bus.valid_uc1 & bus.rename_ready_rn0 & ~bus.useq_last_uc1 & ~nuke) |=>
        (bus.valid_uc1 & (bus.useq_idx_uc1 == $past(bus.useq_idx_uc1) + 1'b1)));

    a_table_len: assert property (@(posedge clk) disable iff (reset)
        ((state == SEQ) & (cnt == SEQ_IDX_W'(MAX_SEQ - 1))) |-> exp_step.last);
`endif

endmodule

// File: tb/tb_ucode_seq.sv
// tb/tb_ucode_seq.sv - directed bench for ucode_seq with a queue-based expected-stream model
module tb_ucode_seq;
    import instr_decode::*;

    logic      clk = 1'b0;
    logic      reset;
    t_nuke_pkt nuke_rb1;

    ucode_seq_if #(.SEQ_IDX_W(2)) bus ();

    ucode_seq #(.MAX_SEQ(4), .SEQ_IDX_W(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .nuke_rb1 (nuke_rb1),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        t_uinstr u;
        int      idx;
        bit      last;
    } t_exp;

    t_exp exp_q[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic t_uinstr mk(input logic [31:0] pc, input logic [7:0] opc, input logic [15:0] imm);
        t_uinstr u;
        u.pc     = pc;
        u.pc_nxt = pc + 32'd4;
        u.simid  = pc[15:0] ^ 16'h5a5a;
        u.opcode = opc;
        u.imm    = imm;
        return u;
    endfunction

    // Every accepted uop becomes its full list of expected micro-ops.
    function automatic void model_push(input t_uinstr p);
        int len;
        len = p.opcode[7] ? int'(p.opcode[1:0]) + 1 : 1;
        for (int k = 0; k < len; k++) begin
            t_exp e;
            e.u     = p;
            e.u.imm = p.imm + 16'(k);
            e.idx   = k;
            e.last  = (k == len - 1);
            exp_q.push_back(e);
        end
    endfunction

    logic [106:0] prev_uc1;
    bit           prev_stall = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {bus.valid_uc1, bus.uinstr_uc1, bus.useq_idx_uc1, bus.useq_last_uc1},
                    {1'b1, prev_uc1});
            if (bus.valid_uc1 && bus.rename_ready_rn0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_uop actual=idx%0d required=none at %0t", bus.useq_idx_uc1, $time);
                end else begin
                    t_exp e;
                    e = exp_q.pop_front();
                    checks--;
                    chk("uc1_vs_model", {bus.uinstr_uc1, bus.useq_idx_uc1, bus.useq_last_uc1},
                        {e.u, 2'(e.idx), e.last});
                end
            end
            if (nuke_rb1.valid) exp_q.delete();
            else if (bus.valid_de1) model_push(bus.uinstr_de1);
            prev_stall = bus.valid_uc1 && !bus.rename_ready_rn0 && !nuke_rb1.valid;
            prev_uc1   = {bus.uinstr_uc1, bus.useq_idx_uc1, bus.useq_last_uc1};
        end
    end

    task automatic cyc(input logic vde, input t_uinstr u, input logic rr, input logic nk);
        @(posedge clk);
        #1;
        bus.valid_de1        = vde;
        bus.uinstr_de1       = u;
        bus.rename_ready_rn0 = rr;
        nuke_rb1.valid       = nk;
        #1;
    endtask

    task automatic see(input string nm, input logic v, input logic [31:0] pc, input logic [15:0] imm,
                       input logic [1:0] idx, input logic last);
        if (v)
            chk(nm, {bus.valid_uc1, bus.uinstr_uc1.pc, bus.uinstr_uc1.imm, bus.useq_idx_uc1, bus.useq_last_uc1},
                {v, pc, imm, idx, last});
        else
            chk(nm, bus.valid_uc1, 1'b0);
    endtask

    t_uinstr z;

    initial begin
        z = '0;
        reset = 1'b1;
        nuke_rb1.valid = 1'b0;
        bus.valid_de1 = 1'b0;
        bus.uinstr_de1 = '0;
        bus.rename_ready_rn0 = 1'b1;
        #2;
        chk("rst_ready", bus.ucode_ready_uc0, 1'b0);
        chk("rst_valid", bus.valid_uc1, 1'b0);
        chk("rst_idx", bus.useq_idx_uc1, 2'd0);
        chk("rst_last", bus.useq_last_uc1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // pass-through stream
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, mk(32'h100 + 32'(4 * i), 8'h01, 16'(i)), 1'b1, 1'b0);
            chk("pass_ready", bus.ucode_ready_uc0, 1'b1);
            if (i > 0) see("pass_out", 1'b1, 32'h100 + 32'(4 * (i - 1)), 16'(i - 1), 2'd0, 1'b1);
        end
        cyc(1'b0, z, 1'b1, 1'b0);
        see("pass_out4", 1'b1, 32'h110, 16'h4, 2'd0, 1'b1);
        cyc(1'b0, z, 1'b1, 1'b0);
        see("pass_idle", 1'b0, 0, 0, 0, 0);

        // length-3 expansion
        cyc(1'b1, mk(32'h200, 8'h82, 16'h0010), 1'b1, 1'b0);
        chk("exp_ready_in", bus.ucode_ready_uc0, 1'b1);
        cyc(1'b0, z, 1'b1, 1'b0);
        see("exp_s0", 1'b1, 32'h200, 16'h10, 2'd0, 1'b0);
        chk("exp_ready_s0", bus.ucode_ready_uc0, 1'b0);
        cyc(1'b0, z, 1'b1, 1'b0);
        see("exp_s1", 1'b1, 32'h200, 16'h11, 2'd1, 1'b0);
        chk("exp_ready_s1", bus.ucode_ready_uc0, 1'b0);
        cyc(1'b0, z, 1'b1, 1'b0);
        see("exp_s2", 1'b1, 32'h200, 16'h12, 2'd2, 1'b1);
        chk("exp_ready_s2", bus.ucode_ready_uc0, 1'b1);
        cyc(1'b0, z, 1'b1, 1'b0);
        see("exp_idle", 1'b0, 0, 0, 0, 0);

        // backpressure while idx 1 sits in UC1
        cyc(1'b1, mk(32'h300, 8'h82, 16'h0020), 1'b1, 1'b0);
        cyc(1'b0, z, 1'b1, 1'b0);
        see("bp_s0", 1'b1, 32'h300, 16'h20, 2'd0, 1'b0);
        cyc(1'b0, z, 1'b0, 1'b0);
        see("bp_s1_a", 1'b1, 32'h300, 16'h21, 2'd1, 1'b0);
        chk("bp_ready_stall", bus.ucode_ready_uc0, 1'b0);
        cyc(1'b0, z, 1'b0, 1'b0);
        see("bp_s1_b", 1'b1, 32'h300, 16'h21, 2'd1, 1'b0);
        cyc(1'b0, z, 1'b1, 1'b0);
        see("bp_s1_c", 1'b1, 32'h300, 16'h21, 2'd1, 1'b0);
        cyc(1'b0, z, 1'b1, 1'b0);
        see("bp_s2", 1'b1, 32'h300, 16'h22, 2'd2, 1'b1);
        cyc(1'b0, z, 1'b1, 1'b0);
        see("bp_idle", 1'b0, 0, 0, 0, 0);

        // nuke with idx 1 of a length-4 uop in UC1
        cyc(1'b1, mk(32'h400, 8'h83, 16'h0030), 1'b1, 1'b0);
        cyc(1'b0, z, 1'b1, 1'b0);
        see("nk_s0", 1'b1, 32'h400, 16'h30, 2'd0, 1'b0);
        cyc(1'b0, z, 1'b1, 1'b1);
        see("nk_s1", 1'b1, 32'h400, 16'h31, 2'd1, 1'b0);
        chk("nk_ready_nuke", bus.ucode_ready_uc0, 1'b0);
        cyc(1'b0, z, 1'b1, 1'b0);
        see("nk_after", 1'b0, 0, 0, 0, 0);
        chk("nk_ready_after", bus.ucode_ready_uc0, 1'b1);
        cyc(1'b1, mk(32'h500, 8'h01, 16'h0040), 1'b1, 1'b0);
        see("nk_gap", 1'b0, 0, 0, 0, 0);
        cyc(1'b0, z, 1'b1, 1'b0);
        see("nk_new", 1'b1, 32'h500, 16'h40, 2'd0, 1'b1);
        cyc(1'b0, z, 1'b1, 1'b0);
        see("nk_no_s2", 1'b0, 0, 0, 0, 0);
        cyc(1'b0, z, 1'b1, 1'b0);
        see("nk_no_s3", 1'b0, 0, 0, 0, 0);

        // nuke together with a pop in IDLE
        cyc(1'b1, mk(32'h600, 8'h01, 16'h0050), 1'b1, 1'b1);
        chk("nkde_ready", bus.ucode_ready_uc0, 1'b0);
        cyc(1'b0, z, 1'b1, 1'b0);
        see("nkde_drop", 1'b0, 0, 0, 0, 0);
        cyc(1'b0, z, 1'b1, 1'b0);
        see("nkde_drop2", 1'b0, 0, 0, 0, 0);

        // asynchronous reset mid-sequence
        cyc(1'b1, mk(32'h700, 8'h83, 16'h0060), 1'b1, 1'b0);
        cyc(1'b0, z, 1'b1, 1'b0);
        see("ar_s0", 1'b1, 32'h700, 16'h60, 2'd0, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk("ar_valid", bus.valid_uc1, 1'b0);
        chk("ar_idx", bus.useq_idx_uc1, 2'd0);
        chk("ar_last", bus.useq_last_uc1, 1'b0);
        chk("ar_ready", bus.ucode_ready_uc0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("ar_ready_after", bus.ucode_ready_uc0, 1'b1);
        see("ar_valid_after", 1'b0, 0, 0, 0, 0);
        cyc(1'b1, mk(32'h800, 8'h01, 16'h0070), 1'b1, 1'b0);
        cyc(1'b0, z, 1'b1, 1'b0);
        see("ar_new", 1'b1, 32'h800, 16'h70, 2'd0, 1'b1);
        cyc(1'b0, z, 1'b1, 1'b0);
        see("ar_idle", 1'b0, 0, 0, 0, 0);
        cyc(1'b0, z, 1'b1, 1'b0);

        chk("model_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
